// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy scoreboard.
// Two combinational read ports with same-cycle write bypass, one write port,
// plus a busy bit per register marking an outstanding producer (Reserve sets
// it, a write clears it, Flush clears all of them).
// Optional feature: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero
// (never written, never busy, reads return 0 with no bypass).
module regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] Rd,
  input  logic [WIDTH-1:0]  WBus,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  output logic [WIDTH-1:0]  Bus1,
  output logic [WIDTH-1:0]  Bus2,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] RdRes,
  input  logic              Flush,
  output logic              Busy1,
  output logic              Busy2,
  output logic              AnyBusy
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] wr_dec;
  logic [DEPTH-1:0] res_dec;

  // Decode write and reserve strobes into one-hot per-register enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_dec  = '0;
    res_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_dec[i]  = RegWr   && (Rd    == ADDR_W'(i));
      res_dec[i] = Reserve && (RdRes == ADDR_W'(i));
    end
`ifdef REGFILE_R0_ZERO_EN
    // Register 0 is a constant: it ignores both writes and reserves.
    wr_dec[0]  = 1'b0;
    res_dec[0] = 1'b0;
`endif
  end

  // Register storage: cleared by reset, one register written per edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this array is reset on purpose (clean operands after reset are
    // required), so it maps to flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block ordering.
        rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_dec[i]) begin
          rf[i] <= WBus;
        end
      end
    end
  end

  // Busy scoreboard: Flush beats Reserve, Reserve beats the write clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (Flush) begin
      busy <= '0;
    end else begin
      // A reserve of the register being written wins: the new producer
      // supersedes the one whose result is landing now.
      busy <= (busy & ~wr_dec) | res_dec;
    end
  end

  // Read port 1: zero while in reset, bypass an in-flight write, else storage.
  always_comb begin
    Bus1 = rf[Rs1];
    if (reset || (R0_ZERO && Rs1 == '0)) begin
      Bus1 = '0;
    end else if (wr_dec[Rs1]) begin
      Bus1 = WBus;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    Bus2 = rf[Rs2];
    if (reset || (R0_ZERO && Rs2 == '0)) begin
      Bus2 = '0;
    end else if (wr_dec[Rs2]) begin
      Bus2 = WBus;
    end
  end

  // Effective hazard status: a write landing this cycle resolves it now,
  // while a reserve issued this cycle only shows up after the edge.
  always_comb begin
    Busy1   = busy[Rs1] && !wr_dec[Rs1];
    Busy2   = busy[Rs2] && !wr_dec[Rs2];
    AnyBusy = |busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic for regfile_sb,
// checked every cycle against an array-based reference model.
module tb_regfile_sb;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2 ** ADDR_W;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              RegWr = 1'b0;
  logic [ADDR_W-1:0] Rd = '0;
  logic [WIDTH-1:0]  WBus = '0;
  logic [ADDR_W-1:0] Rs1 = '0;
  logic [ADDR_W-1:0] Rs2 = '0;
  logic              Reserve = 1'b0;
  logic [ADDR_W-1:0] RdRes = '0;
  logic              Flush = 1'b0;
  logic [WIDTH-1:0]  Bus1, Bus2;
  logic              Busy1, Busy2, AnyBusy;

  int  n_vec = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  logic [WIDTH-1:0] m_rf   [DEPTH];
  bit               m_busy [DEPTH];

  regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .RegWr(RegWr), .Rd(Rd), .WBus(WBus),
    .Rs1(Rs1), .Rs2(Rs2), .Bus1(Bus1), .Bus2(Bus2),
    .Reserve(Reserve), .RdRes(RdRes), .Flush(Flush),
    .Busy1(Busy1), .Busy2(Busy2), .AnyBusy(AnyBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: apply the edge rules in ascending priority order so the
  // last rule to touch a busy bit is the one that wins.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_rf[i]   = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (RegWr && !(R0Z && Rd == 0)) begin
        m_rf[Rd]   = WBus;
        m_busy[Rd] = 1'b0;
      end
      if (Reserve && !(R0Z && RdRes == 0)) m_busy[RdRes] = 1'b1;
      if (Flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] exp_bus(input logic [ADDR_W-1:0] rs);
    if (reset) return '0;
    if (R0Z && rs == 0) return '0;
    if (RegWr && Rd == rs) return WBus;
    return m_rf[rs];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] rs);
    if (reset) return 1'b0;
    if (R0Z && rs == 0) return 1'b0;
    return m_busy[rs] && !(RegWr && Rd == rs);
  endfunction

  function automatic logic exp_any();
    logic a = 1'b0;
    for (int i = 0; i < DEPTH; i++) a = a | m_busy[i];
    return a;
  endfunction

  // Continuous compare, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("Bus1",    32'(Bus1),    32'(exp_bus(Rs1)));
      check("Bus2",    32'(Bus2),    32'(exp_bus(Rs2)));
      check("Busy1",   32'(Busy1),   32'(exp_busy(Rs1)));
      check("Busy2",   32'(Busy2),   32'(exp_busy(Rs2)));
      check("AnyBusy", 32'(AnyBusy), 32'(exp_any()));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWr = 1'b0; Reserve = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    // Reset pulse with a pending write to r3 visible on Rs1.
    RegWr = 1'b1; Rd = 3'd3; WBus = 16'hBEEF; Rs1 = 3'd3;
    #1 reset = 1'b1;
    #1 check("rst_bus1", 32'(Bus1), 32'h0);
    check("rst_any", 32'(AnyBusy), 32'h0);
    #1 reset = 1'b0; RegWr = 1'b0;
    chk_en = 1'b1;
    next();
    check("rst_r3_after", 32'(Bus1), 32'h0);
    check("rst_busy1", 32'(Busy1), 32'h0);

    // Write with bypass, then read back from storage.
    RegWr = 1'b1; Rd = 3'd5; WBus = 16'h1234; Rs1 = 3'd5;
    #1 check("bypass_r5", 32'(Bus1), 32'h1234);
    next(); idle();
    #1 check("stored_r5", 32'(Bus1), 32'h1234);

    // Reserve r2, observe it, then clear it with a write.
    next(); Reserve = 1'b1; RdRes = 3'd2; Rs2 = 3'd2;
    #1 check("res_not_yet", 32'(Busy2), 32'h0);
    next(); idle();
    #1 check("res_busy2", 32'(Busy2), 32'h1);
    check("res_any", 32'(AnyBusy), 32'h1);
    next(); RegWr = 1'b1; Rd = 3'd2; WBus = 16'h00FF;
    #1 check("wr_clr_busy2", 32'(Busy2), 32'h0);
    check("wr_clr_bus2", 32'(Bus2), 32'h00FF);
    check("wr_clr_any_held", 32'(AnyBusy), 32'h1);
    next(); idle();
    #1 check("wr_clr_any", 32'(AnyBusy), 32'h0);

    // Simultaneous reserve and write to r4: data lands, busy ends set.
    next(); RegWr = 1'b1; Rd = 3'd4; WBus = 16'hA5A5; Reserve = 1'b1; RdRes = 3'd4; Rs1 = 3'd4;
    next(); idle();
    #1 check("sim_bus1", 32'(Bus1), 32'hA5A5);
    check("sim_busy1", 32'(Busy1), 32'h1);

    // Flush beats a same-cycle reserve.
    next(); Reserve = 1'b1; RdRes = 3'd1;
    next(); RdRes = 3'd6;
    next(); RdRes = 3'd7;
    next(); RdRes = 3'd3; Flush = 1'b1;
    #1 check("pre_flush_any", 32'(AnyBusy), 32'h1);
    next(); idle(); Rs1 = 3'd4; Rs2 = 3'd3;
    #1 check("flush_any", 32'(AnyBusy), 32'h0);
    check("flush_busy2_r3", 32'(Busy2), 32'h0);
    check("flush_keep_r4", 32'(Bus1), 32'hA5A5);

    // Register 0 write plus reserve.
    next(); RegWr = 1'b1; Rd = 3'd0; WBus = 16'hFFFF; Reserve = 1'b1; RdRes = 3'd0; Rs1 = 3'd0;
    #1 check("r0_same_cycle", 32'(Bus1), R0Z ? 32'h0 : 32'hFFFF);
    check("r0_busy_same", 32'(Busy1), 32'h0);
    next(); idle();
    #1 check("r0_after", 32'(Bus1), R0Z ? 32'h0 : 32'hFFFF);
    check("r0_busy_after", 32'(Busy1), R0Z ? 32'h0 : 32'h1);
    check("r0_any", 32'(AnyBusy), R0Z ? 32'h0 : 32'h1);
    next(); Flush = 1'b1;
    next(); idle();

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 600; n++) begin
      next();
      RegWr   = ($urandom_range(0, 2) != 0);
      Rd      = ADDR_W'($urandom);
      WBus    = WIDTH'($urandom);
      Reserve = ($urandom_range(0, 2) == 0);
      RdRes   = ($urandom_range(0, 3) == 0) ? Rd : ADDR_W'($urandom);
      Flush   = ($urandom_range(0, 15) == 0);
      Rs1     = ($urandom_range(0, 2) == 0) ? Rd : ADDR_W'($urandom);
      Rs2     = ($urandom_range(0, 4) == 0) ? Rs1 : ADDR_W'($urandom);
    end

    // Reset asserted mid-operation with busy bits set.
    next(); idle(); Reserve = 1'b1; RdRes = 3'd6;
    next(); idle(); Rs1 = 3'd6; Rs2 = 3'd5;
    #1 check("mid_busy_set", 32'(AnyBusy), 32'h1);
    reset = 1'b1;
    #1 check("mid_rst_any", 32'(AnyBusy), 32'h0);
    check("mid_rst_busy1", 32'(Busy1), 32'h0);
    #1 reset = 1'b0;
    #1 check("mid_rst_r5", 32'(Bus2), 32'h0);
    next();
    next();

    chk_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
